regfile_dump_ctrl: RTL and testbench

Debug scheduler that sequences a full dump of the 32-entry register file through a shared read port. On a start pulse it walks addresses START_ADDR..NREG-1 and borrows the read port only in cycles where the CPU does not need it. Each captured (address, data) pair is presented to a downstream sink, such as a UART formatter or the simulation print block, over a valid/ready handshake. The block sits beside the register file; an external mux selects dbg_addr onto the read port whenever dbg_grant=1.

---
 rtl/regfile_dump_ctrl.sv | 127 ++++++++++++
 tb/tb_regfile_dump_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_ctrl.sv
// Debug dump sequencer: walks the register file through a shared read port,
// stealing only CPU-idle cycles, and streams (address, data) pairs to a sink.
module regfile_dump_ctrl #(
   parameter int NREG       = 32,
   parameter int AW         = 5,
   parameter int DW         = 32,
   parameter int START_ADDR = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic          cpu_rd_req,
   output logic          dbg_grant,
   output logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] rf_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_addr,
   output logic [DW-1:0] out_data,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [AW-1:0] START_PTR = AW'(START_ADDR);
   localparam logic [AW-1:0] LAST_PTR  = AW'(NREG - 1);

   state_t          state_r, state_s;
   logic [AW-1:0]   ptr_r, ptr_s;
   logic            out_valid_r, out_valid_s;
   logic [AW-1:0]   out_addr_r, out_addr_s;
   logic [DW-1:0]   out_data_r, out_data_s;
   logic            busy_r, done_r;

   // The CPU always wins the shared port; we only borrow it while waiting to capture.
   assign dbg_grant = (state_r == ST_READ) && !cpu_rd_req;
   assign dbg_addr  = ptr_r;
   assign out_valid = out_valid_r;
   assign out_addr  = out_addr_r;
   assign out_data  = out_data_r;
   assign busy      = busy_r;
   assign done      = done_r;

   // Next-state and datapath decode; abort overrides everything except reset.
   always_comb begin
      state_s     = state_r;
      ptr_s       = ptr_r;
      out_valid_s = out_valid_r;
      out_addr_s  = out_addr_r;
      out_data_s  = out_data_r;
      if (abort) begin
         state_s     = ST_IDLE;
         out_valid_s = 1'b0;
         ptr_s       = START_PTR;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  ptr_s   = START_PTR;
                  state_s = ST_READ;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_READ: begin
               // Snapshot is taken here; later register writes are not re-read.
               if (!cpu_rd_req) begin
                  out_data_s  = rf_data;
                  out_addr_s  = ptr_r;
                  out_valid_s = 1'b1;
                  state_s     = ST_HOLD;
               end else begin
                  state_s = ST_READ;
               end
            end
            ST_HOLD: begin
               if (out_valid_r && out_ready) begin
                  out_valid_s = 1'b0;
                  if (ptr_r == LAST_PTR) begin
                     state_s = ST_DONE;
                  end else begin
                     ptr_s   = ptr_r + AW'(1);
                     state_s = ST_READ;
                  end
               end else begin
                  state_s = ST_HOLD;
               end
            end
            ST_DONE: begin
               state_s = ST_IDLE;
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // State, pointer and output registers; busy/done are decoded from the next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         ptr_r       <= START_PTR;
         out_valid_r <= 1'b0;
         out_addr_r  <= {AW{1'b0}};
         out_data_r  <= {DW{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         ptr_r       <= ptr_s;
         out_valid_r <= out_valid_s;
         out_addr_r  <= out_addr_s;
         out_data_r  <= out_data_s;
         busy_r      <= (state_s != ST_IDLE);
         done_r      <= (state_s == ST_DONE);
      end
   end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Self-checking bench for regfile_dump_ctrl: directed scenarios plus randomized
// contention/backpressure against a transaction-level reference model.
module tb_regfile_dump_ctrl;

   localparam int NREG = 32;
   localparam int P_IDLE = 0;
   localparam int P_READ = 1;
   localparam int P_HOLD = 2;
   localparam int P_DONE = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        cpu_rd_req = 1'b0;
   logic        out_ready = 1'b0;
   logic        dbg_grant, out_valid, busy, done;
   logic [4:0]  dbg_addr, out_addr;
   logic [31:0] rf_data, out_data;

   logic [31:0] rf [NREG];
   logic [31:0] snap [NREG];

   // Combinational register-file read port.
   assign rf_data = rf[dbg_addr];

   always #5 clk = ~clk;

   regfile_dump_ctrl #(.NREG(32), .AW(5), .DW(32), .START_ADDR(0)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .cpu_rd_req(cpu_rd_req), .dbg_grant(dbg_grant), .dbg_addr(dbg_addr),
      .rf_data(rf_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done)
   );

   int n_chk = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int cnt;

   int          m_phase, m_ptr;
   logic        m_valid;
   logic [4:0]  m_oaddr;
   logic [31:0] m_odata;

   int          acc_addr [$];
   logic [31:0] acc_data [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = P_IDLE; m_ptr = 0; m_valid = 1'b0; m_oaddr = 5'd0; m_odata = 32'd0;
   endtask

   task automatic check_outputs();
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_addr",  32'(out_addr),  32'(m_oaddr));
      chk("out_data",  out_data,       m_odata);
      chk("busy",      32'(busy),      32'(m_phase != P_IDLE));
      chk("done",      32'(done),      32'(m_phase == P_DONE));
      chk("dbg_grant", 32'(dbg_grant), 32'(m_phase == P_READ && !cpu_rd_req));
      chk("dbg_addr",  32'(dbg_addr),  32'(m_ptr));
   endtask

   // One clock: check at the falling edge, advance the model, return 1 after the rising edge.
   task automatic cycle();
      int nph, nptr;
      logic nv;
      logic [4:0] na;
      logic [31:0] nd;
      @(negedge clk);
      check_outputs();
      if (out_valid && out_ready) begin
         acc_addr.push_back(int'(out_addr));
         acc_data.push_back(out_data);
      end
      if (done) done_cnt++;
      nph = m_phase; nptr = m_ptr; nv = m_valid; na = m_oaddr; nd = m_odata;
      if (abort) begin
         nph = P_IDLE; nv = 1'b0; nptr = 0;
      end else begin
         case (m_phase)
            P_IDLE: if (start) begin nptr = 0; nph = P_READ; end
            P_READ: if (!cpu_rd_req) begin
               na = 5'(m_ptr); nd = rf[m_ptr]; nv = 1'b1; nph = P_HOLD;
            end
            P_HOLD: if (out_ready) begin
               nv = 1'b0;
               if (m_ptr == NREG - 1) nph = P_DONE;
               else begin nptr = m_ptr + 1; nph = P_READ; end
            end
            default: nph = P_IDLE;
         endcase
      end
      @(posedge clk);
      #1;
      if (!reset) model_reset();
      else begin
         m_phase = nph; m_ptr = nptr; m_valid = nv; m_oaddr = na; m_odata = nd;
      end
   endtask

   task automatic begin_dump();
      for (int i = 0; i < NREG; i++) snap[i] = rf[i];
      acc_addr.delete();
      acc_data.delete();
      done_cnt = 0;
      start = 1'b1;
      cycle();
      start = 1'b0;
      cnt = 1;
   endtask

   task automatic run_to_done(input int budget);
      while (!done && cnt < budget) begin
         cycle();
         cnt++;
      end
      chk("dump_done_seen", 32'(done), 32'd1);
   endtask

   task automatic check_dump(input string tag);
      chk({tag, "_count"}, 32'(acc_addr.size()), 32'(NREG));
      for (int k = 0; k < acc_addr.size() && k < NREG; k++) begin
         chk({tag, "_addr"}, 32'(acc_addr[k]), 32'(k));
         chk({tag, "_data"}, acc_data[k], snap[k]);
      end
   endtask

   initial begin
      model_reset();
      for (int i = 0; i < NREG; i++) rf[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
      #1 reset = 1'b0;
      cycle();
      cycle();
      reset = 1'b1;
      cycle();

      // Basic dump with free-flowing sink.
      out_ready = 1'b1;
      begin_dump();
      run_to_done(200);
      chk("basic_latency", 32'(cnt), 32'd65);
      cycle();
      chk("busy_after_done", 32'(busy), 32'd0);
      check_dump("basic");
      if (acc_data.size() == NREG) begin
         chk("basic_word0", acc_data[0], 32'd0);
         chk("basic_word5", acc_data[5], 32'h1000_0005);
      end
      chk("basic_done_pulses", 32'(done_cnt), 32'd1);

      // Contention at ptr 3, restart attempt at ptr 9, backpressure on word 12.
      begin_dump();
      while (!(m_phase == P_READ && m_ptr == 3) && cnt < 200) begin cycle(); cnt++; end
      cpu_rd_req = 1'b1;
      for (int i = 0; i < 7; i++) begin
         cycle(); cnt++;
         chk("contention_no_capture", 32'(out_valid), 32'd0);
      end
      cpu_rd_req = 1'b0;
      while (!(m_phase == P_READ && m_ptr == 9) && cnt < 200) begin cycle(); cnt++; end
      start = 1'b1;
      cycle(); cnt++;
      start = 1'b0;
      while (!(m_phase == P_HOLD && m_oaddr == 5'd12) && cnt < 200) begin cycle(); cnt++; end
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle(); cnt++;
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_addr", 32'(out_addr), 32'd12);
      end
      out_ready = 1'b1;
      run_to_done(300);
      chk("stall_latency", 32'(cnt), 32'd82);
      for (int i = 0; i < 4; i++) cycle();
      chk("stall_done_pulses", 32'(done_cnt), 32'd1);
      check_dump("stall");

      // Abort while holding word 20, then a fresh dump from address 0.
      begin_dump();
      while (!(m_phase == P_HOLD && m_ptr == 20) && cnt < 200) begin cycle(); cnt++; end
      abort = 1'b1;
      out_ready = 1'b0;
      cycle();
      abort = 1'b0;
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_keeps_addr", 32'(out_addr), 32'd20);
      for (int i = 0; i < 5; i++) cycle();
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      abort = 1'b1;
      start = 1'b1;
      cycle();
      abort = 1'b0;
      start = 1'b0;
      chk("abort_beats_start", 32'(busy), 32'd0);
      out_ready = 1'b1;
      begin_dump();
      run_to_done(200);
      check_dump("restart");

      // Randomized contention, backpressure, stray starts and post-capture writes.
      for (int d = 0; d < 4; d++) begin
         for (int i = 1; i < NREG; i++) rf[i] = $urandom;
         rf[0] = 32'd0;
         out_ready = 1'b1;
         cpu_rd_req = 1'b0;
         begin_dump();
         while (!done && cnt < 2000) begin
            cpu_rd_req = ($urandom_range(0, 99) < 30);
            out_ready  = ($urandom_range(0, 99) < 60);
            start      = ($urandom_range(0, 19) == 0);
            if (m_valid && $urandom_range(0, 1) == 1) rf[m_oaddr] = $urandom;
            cycle();
            cnt++;
         end
         start = 1'b0;
         cpu_rd_req = 1'b0;
         chk("rand_done_seen", 32'(done), 32'd1);
         cycle();
         check_dump("rand");
      end

      // Asynchronous reset between edges while stalled in READ.
      out_ready = 1'b1;
      begin_dump();
      while (!(m_phase == P_READ && m_ptr == 4) && cnt < 200) begin cycle(); cnt++; end
      cpu_rd_req = 1'b1;
      cycle();
      #2;
      cpu_rd_req = 1'b0;
      reset = 1'b0;
      #1;
      chk("areset_valid", 32'(out_valid), 32'd0);
      chk("areset_addr", 32'(out_addr), 32'd0);
      chk("areset_data", out_data, 32'd0);
      chk("areset_busy", 32'(busy), 32'd0);
      chk("areset_done", 32'(done), 32'd0);
      chk("areset_grant", 32'(dbg_grant), 32'd0);
      chk("areset_ptr", 32'(dbg_addr), 32'd0);
      model_reset();
      cycle();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      chk("areset_stays_idle", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
